// File: rtl/morse_keyer_sequencer.sv
// Morse letter sequencer: turns captured symbol bits/count into a timed key
// signal with dot/dash/space/gap durations measured in UNIT_CYCLES clocks.
module morse_keyer_sequencer #(
  parameter int UNIT_CYCLES = 4,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] code,
  input  logic [2:0] len,
  input  logic       abort,
  output logic       key,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_MARK   = 3'd1;
  localparam logic [2:0] S_SPACE  = 3'd2;
  localparam logic [2:0] S_LGAP   = 3'd3;
  localparam logic [2:0] S_WSPACE = 3'd4;

  localparam logic [CNT_W-1:0] L_DOT  = CNT_W'(UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_DASH = CNT_W'(3 * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_LGAP = CNT_W'(3 * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_WSP  = CNT_W'(7 * UNIT_CYCLES - 1);

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic [3:0]       r_code;
  logic             r_key;
  logic             r_busy;
  logic             r_done;

  logic [2:0]       w_next_state;
  logic [CNT_W-1:0] w_next_cnt;
  logic [1:0]       w_next_idx;
  logic [3:0]       w_next_code;
  logic [1:0]       w_first_idx;
  logic             w_cnt_zero;

  assign in_ready = (r_state == S_IDLE);
  assign key      = r_key;
  assign busy     = r_busy;
  assign done     = r_done;

  assign w_cnt_zero = (r_cnt == '0);
  // len 5..7 behaves as 4, so the first symbol index saturates at 3
  assign w_first_idx = (len >= 3'd4) ? 2'd3 : (len[1:0] - 2'd1);

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_idx   = r_idx;
    w_next_code  = r_code;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_next_code = code;
          if (len == 3'd0) begin
            w_next_state = S_WSPACE;
            w_next_cnt   = L_WSP;
          end else begin
            w_next_state = S_MARK;
            w_next_idx   = w_first_idx;
            w_next_cnt   = code[w_first_idx] ? L_DASH : L_DOT;
          end
        end
      end
      S_MARK: begin
        if (w_cnt_zero) begin
          if (r_idx == 2'd0) begin
            w_next_state = S_LGAP;
            w_next_cnt   = L_LGAP;
          end else begin
            w_next_state = S_SPACE;
            w_next_cnt   = L_DOT;
          end
        end else begin
          w_next_cnt = r_cnt - CNT_W'(1);
        end
      end
      S_SPACE: begin
        if (w_cnt_zero) begin
          w_next_state = S_MARK;
          w_next_idx   = r_idx - 2'd1;
          w_next_cnt   = r_code[r_idx - 2'd1] ? L_DASH : L_DOT;
        end else begin
          w_next_cnt = r_cnt - CNT_W'(1);
        end
      end
      S_LGAP, S_WSPACE: begin
        if (w_cnt_zero) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_cnt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_cnt   = '0;
      end
    endcase
    if (abort && (r_state != S_IDLE)) begin
      w_next_state = S_IDLE;
      w_next_cnt   = '0;
    end
  end

  // Outputs are decoded from the next state so they are registered yet
  // aligned with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_code  <= '0;
      r_key   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_idx   <= w_next_idx;
      r_code  <= w_next_code;
      r_key   <= (w_next_state == S_MARK);
      r_busy  <= (w_next_state != S_IDLE);
      r_done  <= ((w_next_state == S_LGAP) || (w_next_state == S_WSPACE))
                 && (w_next_cnt == '0);
    end
  end

endmodule

// File: tb/tb_morse_keyer_sequencer.sv
// Self-checking bench: each letter's key waveform is rebuilt from the Morse
// timing rules and compared cycle by cycle against the sequencer outputs.
module tb_morse_keyer_sequencer;

  localparam int U = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] code = '0;
  logic [2:0] len = '0;
  logic       abort = 1'b0;
  logic       key;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;
  logic exp_q[$];

  morse_keyer_sequencer #(.UNIT_CYCLES(U), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .code(code), .len(len), .abort(abort), .key(key), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, expv, $time);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".key"}, key, 1'b0);
    chk({tag, ".busy"}, busy, 1'b0);
    chk({tag, ".done"}, done, 1'b0);
    chk({tag, ".ready"}, in_ready, 1'b1);
  endtask

  // Expected key level for every cycle of a letter, from the timing rules.
  function automatic void build(input logic [3:0] c, input logic [2:0] l);
    int n;
    exp_q.delete();
    n = (l > 3'd4) ? 4 : int'(l);
    if (n == 0) begin
      for (int i = 0; i < 7 * U; i++) exp_q.push_back(1'b0);
    end else begin
      for (int s = n - 1; s >= 0; s--) begin
        for (int i = 0; i < (c[s] ? 3 : 1) * U; i++) exp_q.push_back(1'b1);
        if (s != 0) for (int i = 0; i < U; i++) exp_q.push_back(1'b0);
      end
      for (int i = 0; i < 3 * U; i++) exp_q.push_back(1'b0);
    end
  endfunction

  // Called at a negedge of an IDLE cycle; returns at the negedge of the
  // IDLE cycle that follows the letter.
  task automatic run_letter(input string tag, input logic [3:0] c, input logic [2:0] l,
                            input logic hold, input logic ab);
    chk_idle({tag, ".pre"});
    code = c; len = l; in_valid = 1'b1; abort = ab;
    build(c, l);
    @(posedge clk); #1;
    abort = 1'b0;
    if (!hold) in_valid = 1'b0;
    code = 4'($urandom); len = 3'($urandom);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      chk({tag, ".key"}, key, exp_q[i]);
      chk({tag, ".busy"}, busy, 1'b1);
      chk({tag, ".ready"}, in_ready, 1'b0);
      chk({tag, ".done"}, done, (i == exp_q.size() - 1));
    end
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_idle("reset");
    rst_n = 1'b1;

    run_letter("E", 4'b0000, 3'd1, 1'b0, 1'b0);
    run_letter("N", 4'b0010, 3'd2, 1'b0, 1'b0);
    run_letter("Q", 4'b1101, 3'd4, 1'b0, 1'b0);
    run_letter("wsp", 4'b0000, 3'd0, 1'b0, 1'b0);
    run_letter("strE", 4'b0000, 3'd1, 1'b1, 1'b0);
    run_letter("strN", 4'b0010, 3'd2, 1'b1, 1'b0);
    run_letter("strG", 4'b0110, 3'd3, 1'b0, 1'b0);

    // abort during the first dash of Q, in its 4th cycle
    code = 4'b1101; len = 3'd4; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("abq.key", key, 1'b1);
    end
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    run_letter("abE", 4'b0000, 3'd1, 1'b0, 1'b0);

    run_letter("idleab", 4'b0010, 3'd2, 1'b0, 1'b1);

    // abort on the edge that ends the done cycle
    code = 4'b0000; len = 3'd1; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("abdone.done", done, 1'b1);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);

    // asynchronous reset in the middle of a mark
    code = 4'b1101; len = 3'd4; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rstq.key", key, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst.key", key, 1'b0);
    chk("rst.busy", busy, 1'b0);
    chk("rst.ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    run_letter("rstE", 4'b0000, 3'd1, 1'b0, 1'b0);

    run_letter("len6", 4'b1011, 3'd6, 1'b0, 1'b0);
    run_letter("hibits", 4'b1110, 3'd1, 1'b0, 1'b0);

    for (int k = 0; k < 24; k++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        @(negedge clk);
        chk_idle("gap");
      end
      run_letter("rnd", 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                 (k != 23) && ($urandom_range(0, 1) == 1), 1'b0);
    end
    in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
